// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Sequencing controller for the multi-cycle multiply unit.
//                Accepts one issue at a time, runs a WIDTH-step radix-2
//                shift-add on operand magnitudes, sign-corrects the double-
//                width product and writes it back as two words through a
//                register-file port shared with (and yielding to) the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 issue_signed,
    input  logic                 issue_rw,
    input  logic [REGW-1:0]      issue_da,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 ex_wr_en,
    input  logic                 flush,
    output logic                 wb_en,
    output logic [REGW-1:0]      wb_da,
    output logic [WIDTH-1:0]     wb_data,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy_valid,
    output logic [REGW-1:0]      busy_da
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FIX   = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4
    } state_t;

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_neg;
    logic                   r_rw;
    logic [REGW-1:0]        r_da;
    logic [2*WIDTH-1:0]     r_product;

    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_neg;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_fixed;

    // Operand magnitudes and result sign; the most negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned magnitude.
    always_comb begin
        w_a_mag = multiplicand;
        w_b_mag = multiplier;
        if (issue_signed && multiplicand[WIDTH-1]) w_a_mag = ~multiplicand + 1'b1;
        if (issue_signed && multiplier[WIDTH-1])   w_b_mag = ~multiplier + 1'b1;
        w_neg = issue_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
    end

    // One shift-add step: carry-preserving add into the upper half, and the
    // sign correction applied to the finished accumulator.
    always_comb begin
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
        w_fixed = r_neg ? ((~r_acc) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;
    end

    // Control FSM together with the datapath registers it sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_rw      <= 1'b0;
            r_da      <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A flush in the same cycle suppresses the accept.
                    if (issue_valid && !flush) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= w_neg;
                        r_rw     <= issue_rw;
                        r_da     <= issue_da;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_STEP) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_product <= w_fixed;
                        r_state   <= r_rw ? S_WB_LO : S_IDLE;
                    end
                end
                // Writeback words wait out any cycle the ALU owns the port;
                // flush is deliberately ignored once writeback has begun.
                S_WB_LO: if (!ex_wr_en) r_state <= S_WB_HI;
                S_WB_HI: if (!ex_wr_en) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode: handshake and write strobes follow state, with the
    // write strobe yielding to the ALU in the same cycle.
    always_comb begin
        issue_ready = (r_state == S_IDLE);
        done        = (r_state == S_FIX) && !flush;
        wb_en       = 1'b0;
        wb_da       = '0;
        wb_data     = '0;
        if (r_state == S_WB_LO) begin
            wb_en   = !ex_wr_en;
            wb_da   = r_da;
            wb_data = r_product[WIDTH-1:0];
        end else if (r_state == S_WB_HI) begin
            wb_en   = !ex_wr_en;
            wb_da   = r_da + 1'b1;
            wb_data = r_product[2*WIDTH-1:WIDTH];
        end
        product    = r_product;
        busy_valid = r_rw && (r_state != S_IDLE);
        busy_da    = r_da;
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Self-checking bench for mul_seq_ctrl: cycle-level reference
//                model compared every cycle, plus directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        issue_signed = 1'b0;
    logic        issue_rw = 1'b0;
    logic [4:0]  issue_da = '0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        ex_wr_en = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_da;
    logic [31:0] wb_data;
    logic [63:0] product;
    logic        done;
    logic        busy_valid;
    logic [4:0]  busy_da;

    int total = 0;
    int bad   = 0;

    mul_seq_ctrl #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_signed(issue_signed), .issue_rw(issue_rw), .issue_da(issue_da),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .ex_wr_en(ex_wr_en), .flush(flush),
        .wb_en(wb_en), .wb_da(wb_da), .wb_data(wb_data),
        .product(product), .done(done),
        .busy_valid(busy_valid), .busy_da(busy_da)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 computing (t counts cycles, 33 = result
    // cycle), 2 low word pending, 3 high word pending. Product by plain math.
    int          m_mode = 0;
    int          m_t = 0;
    logic [63:0] m_p = '0;
    logic [63:0] m_prod = '0;
    logic [4:0]  m_da = '0;
    logic        m_rw = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_t <= 0; m_p <= '0; m_prod <= '0; m_da <= '0; m_rw <= 1'b0;
        end else begin
            case (m_mode)
                0: if (issue_valid && !flush) begin
                    m_mode <= 1;
                    m_t    <= 1;
                    m_da   <= issue_da;
                    m_rw   <= issue_rw;
                    if (issue_signed)
                        m_p <= $signed({{32{multiplicand[31]}}, multiplicand})
                             * $signed({{32{multiplier[31]}}, multiplier});
                    else
                        m_p <= {32'd0, multiplicand} * {32'd0, multiplier};
                end
                1: begin
                    if (flush) m_mode <= 0;
                    else if (m_t == 33) begin
                        m_prod <= m_p;
                        m_mode <= m_rw ? 2 : 0;
                    end else m_t <= m_t + 1;
                end
                2: if (!ex_wr_en) m_mode <= 3;
                3: if (!ex_wr_en) m_mode <= 0;
                default: m_mode <= 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [109:0] act, exp;
        logic [4:0]   e_da;
        logic [31:0]  e_data;
        e_da   = (m_mode == 2) ? m_da : (m_mode == 3) ? m_da + 5'd1 : 5'd0;
        e_data = (m_mode == 2) ? m_prod[31:0] : (m_mode == 3) ? m_prod[63:32] : 32'd0;
        exp = {m_mode == 0, (m_mode == 1 && m_t == 33 && !flush),
               (m_mode >= 2 && !ex_wr_en), e_da, e_data, m_prod,
               (m_mode != 0 && m_rw), m_da};
        act = {issue_ready, done, wb_en, wb_da, wb_data, product, busy_valid, busy_da};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_model t=%0t act=%h exp=%h", $time, act, exp);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Per-operation observations (edge index k after the accept edge E0).
    int          done_k, lo_k, hi_k, rdy_k, nwb;
    logic [4:0]  lo_da, hi_da;
    logic [31:0] lo_data, hi_data;

    task automatic run_op(input logic sg, input logic rw, input logic [4:0] da,
                          input logic [31:0] a, input logic [31:0] b,
                          input int ex_from, input int ex_to,
                          input int flush_at, input int rst_at);
        done_k = -1; lo_k = -1; hi_k = -1; rdy_k = -1; nwb = 0;
        lo_da = '0; hi_da = '0; lo_data = '0; hi_data = '0;
        @(posedge clk); #2;
        issue_valid = 1'b1; issue_signed = sg; issue_rw = rw; issue_da = da;
        multiplicand = a; multiplier = b;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #2;
            issue_valid = 1'b0;
            ex_wr_en = (k >= ex_from && k <= ex_to);
            flush    = (k == flush_at);
            @(negedge clk);
            if (done) done_k = k;
            if (wb_en) begin
                nwb++;
                if (nwb == 1) begin lo_k = k; lo_da = wb_da; lo_data = wb_data; end
                else begin hi_k = k; hi_da = wb_da; hi_data = wb_data; end
            end
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1 check("async_reset_outputs",
                         64'({issue_ready, done, wb_en, wb_da, wb_data, busy_valid, busy_da}),
                         64'({1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0}));
                check("async_reset_product", product, 64'd0);
                #1 rst = 1'b0;
                rdy_k = k;
                break;
            end
            if (issue_ready) begin rdy_k = k; break; end
        end
        ex_wr_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        #1;
        check("reset_ready", 64'(issue_ready), 64'd1);
        check("reset_product", product, 64'd0);
        check("reset_wb_done", 64'({wb_en, done, busy_valid}), 64'd0);

        // Unsigned 7 x 6, full writeback timeline.
        run_op(1'b0, 1'b1, 5'd4, 32'd7, 32'd6, -1, -1, -1, -1);
        check("u7x6_done_cycle", 64'(done_k), 64'd32);
        check("u7x6_product", product, 64'd42);
        check("u7x6_lo_cycle", 64'(lo_k), 64'd33);
        check("u7x6_lo", {27'd0, lo_da, lo_data}, {27'd0, 5'd4, 32'h0000002A});
        check("u7x6_hi_cycle", 64'(hi_k), 64'd34);
        check("u7x6_hi", {27'd0, hi_da, hi_data}, {27'd0, 5'd5, 32'h0});
        check("u7x6_ready_cycle", 64'(rdy_k), 64'd35);
        check("u7x6_wb_count", 64'(nwb), 64'd2);

        // Signed -3 x 5, compute only.
        run_op(1'b1, 1'b0, 5'd9, 32'hFFFFFFFD, 32'd5, -1, -1, -1, -1);
        check("s_m3x5_product", product, 64'hFFFFFFFF_FFFFFFF1);
        check("s_m3x5_done_cycle", 64'(done_k), 64'd32);
        check("s_m3x5_ready_cycle", 64'(rdy_k), 64'd33);
        check("s_m3x5_no_wb", 64'(nwb), 64'd0);

        // Signed most-negative squared, with writeback.
        run_op(1'b1, 1'b1, 5'd2, 32'h80000000, 32'h80000000, -1, -1, -1, -1);
        check("s_min_sq_product", product, 64'h40000000_00000000);
        check("s_min_sq_hi", {27'd0, hi_da, hi_data}, {27'd0, 5'd3, 32'h40000000});

        // All-ones operands, unsigned then signed.
        run_op(1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, -1);
        check("u_ones_product", product, 64'hFFFFFFFE_00000001);
        run_op(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, -1);
        check("s_ones_product", product, 64'd1);

        // ALU owns the port in cycles 34-36; da = 31 wraps for the high word.
        run_op(1'b0, 1'b1, 5'd31, 32'h12345678, 32'h10, 33, 35, -1, -1);
        check("stall_lo_cycle", 64'(lo_k), 64'd36);
        check("stall_hi_cycle", 64'(hi_k), 64'd37);
        check("stall_lo", {27'd0, lo_da, lo_data}, {27'd0, 5'd31, 32'h23456780});
        check("stall_hi", {27'd0, hi_da, hi_data}, {27'd0, 5'd0, 32'h1});
        check("stall_ready_cycle", 64'(rdy_k), 64'd38);

        // Flush in cycle 10: back to idle with no result.
        run_op(1'b0, 1'b1, 5'd6, 32'd3, 32'd3, -1, -1, 9, -1);
        check("flush_ready_cycle", 64'(rdy_k), 64'd10);
        check("flush_no_done", 64'(done_k), 64'hFFFFFFFF_FFFFFFFF);
        check("flush_no_wb", 64'(nwb), 64'd0);
        check("flush_product_kept", product, 64'h00000001_23456780);

        // Asynchronous reset in cycle 20, then a normal operation.
        run_op(1'b0, 1'b1, 5'd8, 32'd11, 32'd13, -1, -1, -1, 19);
        check("post_reset_ready", 64'(issue_ready), 64'd1);
        run_op(1'b1, 1'b1, 5'd7, 32'd100, 32'd200, -1, -1, -1, -1);
        check("after_reset_product", product, 64'd20000);
        check("after_reset_lo", {27'd0, lo_da, lo_data}, {27'd0, 5'd7, 32'h00004E20});
        check("after_reset_hi", {27'd0, hi_da, hi_data}, {27'd0, 5'd8, 32'h0});
        check("after_reset_ready_cycle", 64'(rdy_k), 64'd35);

        @(posedge clk); @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for the multi-cycle multiply unit in the second execute stage. It accepts one multiply issue at a time, converts signed operands to magnitudes, and runs a 32-step radix-2 shift-add. It then sign-corrects the 64-bit product and writes it back as two 32-bit words (low to DA, high to DA+1) through the shared register-file write port. That port is arbitrated against the single-cycle ALU writeback, which always wins.

## Interface
Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- REGW, 5, register address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  multiply request from decode/execute.
- issue_ready  out  1  controller can accept a request; high only in IDLE.
- issue_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- issue_rw  in  1  1 = write the result back; 0 = compute only.
- issue_da  in  REGW  destination register for the low word.
- multiplicand, multiplier  in  WIDTH  operands, sampled only on accept.
- ex_wr_en  in  1  ALU path is using the write port this cycle.
- flush  in  1  synchronous abort from pipeline control.
- wb_en  out  1  write strobe to the register file.
- wb_da  out  REGW  write address.
- wb_data  out  WIDTH  write data.
- product  out  2*WIDTH  final signed/unsigned product; held until the next accept.
- done  out  1  one-cycle pulse when the product is valid (FIX to next state).
- busy_valid, busy_da  out  1, REGW  hazard info: a pending destination exists, and its low register.

## Operation
- States: IDLE, RUN, FIX, WB_LO, WB_HI.
- Accept rule: a request is accepted on a rising edge with issue_valid && issue_ready.
  - Latch the magnitudes, the negate flag, issue_rw and issue_da.
  - Clear the accumulator and set step count = 0.
  - Go to RUN.
- Magnitude conversion (signed mode): an operand with bit 31 set is replaced by ~x+1, interpreted as unsigned. 0x80000000 maps to 2^31, which is legal.
- Negate flag = issue_signed & (a[31] ^ b[31]). In unsigned mode there is no conversion and no negate.
- RUN, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator (33-bit carry-preserving add).
  - Shift the {carry, accumulator} right by 1.
  - After step 31 (32 cycles), go to FIX.
- FIX: product <= negate ? (~acc + 1) : acc, computed mod 2^64. Pulse done. Next state is WB_LO if rw, else IDLE.
- WB_LO: drive wb_da = da and wb_data = product[31:0].
  - wb_en = !ex_wr_en.
  - If ex_wr_en is high, hold the state and retry next cycle; otherwise go to WB_HI.
- WB_HI: same handshake as WB_LO with wb_da = da+1 mod 2^REGW (31 wraps to 0) and wb_data = product[63:32]. When granted, go to IDLE.
- busy_valid is high from the cycle after accept until the cycle after the WB_HI grant, and only when rw = 1. busy_da = latched da.
- flush:
  - In RUN or FIX: return to IDLE next edge, with no writeback and no done, and product unchanged.
  - In WB_LO/WB_HI: ignored; the writeback completes.
  - In IDLE: blocks the accept in that same cycle.
- Reset, including mid-operation: state IDLE, and all outputs 0 except issue_ready = 1.

## Timing
- Accept at edge E0, then RUN for cycles 1–32, FIX in cycle 33 (done high), WB_LO in cycle 34, WB_HI in cycle 35, IDLE and issue_ready in cycle 36.
- The no-writeback case returns to IDLE in cycle 34.
- Each cycle ex_wr_en is high during WB_LO/WB_HI adds one cycle of latency; the controller never writes while ex_wr_en is high.
- wb_en never asserts for more than one cycle per word. Exactly two write strobes per rw = 1 operation.
- issue_ready is combinational from state only; it never depends on issue_valid.

## Test plan
- Unsigned 7 × 6, da = 4, rw = 1: done at cycle 33, product = 42. wb (4, 0x0000002A) in cycle 34, then (5, 0) in cycle 35; issue_ready in cycle 36.
- Signed −3 × 5 (0xFFFFFFFD, 5): product = 0xFFFFFFFF_FFFFFFF1. Signed 0x80000000 × 0x80000000: product = 0x40000000_00000000.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF: product = 0xFFFFFFFE_00000001. Same operands signed: product = 1.
- ex_wr_en high in cycles 34–36: wb_en stays 0 then; low word written in 37, high word in 38. With da = 31, the high word goes to 0.
- flush in cycle 10: IDLE and issue_ready = 1 in cycle 11, with no done, no wb_en, and product unchanged. rw = 0: done in 33, no wb_en, and ready in 34.
- rst pulsed in cycle 20 (asynchronously, mid-clock): all outputs 0 immediately, issue_ready = 1. A new issue accepts normally afterwards and completes with correct values.
